apb_slave_mem: RTL

- APB completer (responder) sitting at the far end of the AHB-to-APB bridge.
- Answers the bridge's APB initiator: decodes one select line, applies a programmable number of wait states, and services reads and writes against an internal word-addressed register memory.
- Reports out-of-range and unaligned accesses via pslverr.
- Serves both as a synthesisable peripheral and as the standard slave model on the bridge testbench in place of the passive loopback.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_wait_counter.sv | 41 ++++
 rtl/apb_slave_mem.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg: shared APB slave types, bus widths and address-decode helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // An access errors when it falls below the window, past its end, or is not word aligned.
  function automatic logic apb_decode_err(
    input logic [APB_ADDR_W-1:0] addr,
    input logic [APB_ADDR_W-1:0] base,
    input logic [APB_ADDR_W-1:0] span
  );
    logic [APB_ADDR_W-1:0] off;
    off = addr - base;
    return (addr < base) || (off >= span) || (addr[1:0] != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_counter.sv
// ---------------------------------------------------------------------------
// apb_wait_counter: loadable down-counter, done while the count is one. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem: APB completer with programmable wait states over a word memory. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned     SEL_IDX     = 0,
  parameter logic [31:0]     BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned     DEPTH       = 16,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [2:0]            pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     SPAN    = 32'(DEPTH * 4);
  localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);

  apb_state_e            state_d, state_q;
  logic                  write_d, write_q;
  logic                  err_d, err_q;
  logic [IDX_W-1:0]      idx_d, idx_q;
  logic [APB_DATA_W-1:0] wdata_d, wdata_q;
  logic                  pready_d, pready_q;
  logic                  pslverr_d, pslverr_q;
  logic [APB_DATA_W-1:0] prdata_d, prdata_q;
  logic [APB_DATA_W-1:0] mem_d [DEPTH];
  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  logic                  sel;
  logic [APB_ADDR_W-1:0] off;
  logic [IDX_W-1:0]      idx_w;
  logic                  err_w;
  logic                  cnt_load, cnt_dec, cnt_done;
  logic                  mem_we;
  logic                  pselx_unused;

  assign sel          = pselx[SEL_IDX];
  assign pselx_unused = ^pselx;
  assign off          = paddr - BASE_ADDR;
  assign idx_w        = IDX_W'(off >> 2);
  assign err_w        = apb_decode_err(paddr, BASE_ADDR, SPAN);

  apb_wait_counter #(
    .CNT_W (4)
  ) u_wait_counter (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .load     (cnt_load),
    .load_val (WS_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        // penable without a preceding setup phase is ignored here.
        if (sel && !penable) begin
          state_d  = ACCESS;
          write_d  = pwrite;
          err_d    = err_w;
          idx_d    = idx_w;
          wdata_d  = pwdata;
          cnt_load = 1'b1;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_w;
            prdata_d  = (!pwrite && !err_w) ? mem_q[idx_w] : '0;
          end
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (penable) begin
          if (pready_q) begin
            mem_we    = write_q && !err_q;
            state_d   = IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end else begin
            cnt_dec = 1'b1;
            if (cnt_done) begin
              pready_d  = 1'b1;
              pslverr_d = err_q;
              prdata_d  = (!write_q && !err_q) ? mem_q[idx_q] : '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) begin
      mem_d[idx_q] = wdata_q;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      mem_q     <= mem_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

`default_nettype wire
